// File: rtl/z80_bus_responder_pkg.sv
// Shared types for the Z80 bus responder: bus FSM states and the address-window compare.
package z80_bus_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } bus_state_t;

    function automatic logic in_window(input logic [15:0] adr,
                                       input logic [15:0] base,
                                       input logic [15:0] top);
        return (adr >= base) && (adr <= top);
    endfunction

endpackage

// File: rtl/z80_irq_gen.sv
// Vblank-driven maskable interrupt: synchronise, detect rising edge, hold intreq
// until the CPU acknowledges or the timeout counter runs out.
module z80_irq_gen #(
    parameter int INT_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic vblank,
    input  logic intack,
    output logic intreq
);
    localparam int CW = $clog2(INT_TIMEOUT);
    localparam logic [CW-1:0] RELOAD = CW'(INT_TIMEOUT - 1);

    logic [2:0]    sync;
    logic          rise;
    logic [CW-1:0] cnt;

    // sync[1:0] is the synchroniser, sync[2] is the previous sample for edge detect
    assign rise = sync[1] & ~sync[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= '0;
            cnt    <= '0;
            intreq <= 1'b0;
        end else begin
            sync <= {sync[1:0], vblank};
            if (rise) begin
                intreq <= 1'b1;
                cnt    <= RELOAD;
            end else if (intreq && (intack || cnt == '0)) begin
                intreq <= 1'b0;
            end else if (intreq) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/z80_bus_responder.sv
// Serves CPU accesses inside an address window from external memory via req/ack,
// stalling the CPU with pause until the data is available; also hosts the vblank IRQ.
module z80_bus_responder
    import z80_bus_responder_pkg::*;
#(
    parameter logic [15:0] WIN_BASE    = 16'h0000,
    parameter logic [15:0] WIN_TOP     = 16'h7FFF,
    parameter int          INT_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_adr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_pause,
    output logic        cpu_intreq,
    input  logic        cpu_intack,
    input  logic        vblank,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_adr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);
    bus_state_t  state, state_nx;
    logic        hit;
    logic [15:0] win_adr;

    assign win_adr = cpu_adr - WIN_BASE;
    assign hit     = (cpu_rd | cpu_wr) & in_window(cpu_adr, WIN_BASE, WIN_TOP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (hit)     state_nx = ST_REQ;
            ST_REQ:  if (mem_ack) state_nx = ST_DONE;
            // a new address while the strobe stays up still passes through IDLE
            ST_DONE: if (!hit || win_adr != mem_adr) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // pause is gated by reset so a held strobe cannot stall the CPU during reset
    always_comb begin
        mem_req   = (state == ST_REQ);
        cpu_pause = reset_n & hit & (state != ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_adr   <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            cpu_din   <= '0;
        end else begin
            if (state == ST_IDLE && hit) begin
                mem_adr   <= win_adr;
                mem_we    <= cpu_wr;
                mem_wdata <= cpu_dout;
            end
            if (state == ST_REQ && mem_ack && !mem_we)
                cpu_din <= mem_rdata;
        end
    end

    z80_irq_gen #(
        .INT_TIMEOUT(INT_TIMEOUT)
    ) u_irq (
        .clk    (clk),
        .reset_n(reset_n),
        .vblank (vblank),
        .intack (cpu_intack),
        .intreq (cpu_intreq)
    );

endmodule

// File: tb/tb_z80_bus_responder.sv
// Bench for z80_bus_responder: vector table, hand-written corner sequences and
// randomized accesses checked against a window/shadow-memory model.
module tb_z80_bus_responder;
    localparam logic [15:0] WIN_BASE = 16'h0000;
    localparam logic [15:0] WIN_TOP  = 16'h7FFF;
    localparam int          T        = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_adr;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_dout, cpu_din;
    logic        cpu_pause, cpu_intreq, cpu_intack, vblank;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_adr;
    logic [7:0]  mem_wdata, mem_rdata;

    z80_bus_responder #(.WIN_BASE(WIN_BASE), .WIN_TOP(WIN_TOP), .INT_TIMEOUT(T)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_adr(cpu_adr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_pause(cpu_pause), .cpu_intreq(cpu_intreq),
        .cpu_intack(cpu_intack), .vblank(vblank), .mem_req(mem_req), .mem_we(mem_we),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] adr;
        logic        rd, wr;
        logic [7:0]  wdata;
        int          delay;
        logic        exp_hit;
        logic [7:0]  exp_din;
    } vec_t;

    int         n_cmp = 0, n_err = 0;
    logic [7:0] ext_mem [0:32767];
    logic [7:0] shadow  [0:32767];
    logic [7:0] cur_din;
    vec_t       vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // one CPU access plus the external memory responder side
    task automatic access(input vec_t v, input string tag);
        logic        saw, stable;
        logic [15:0] exp_adr;
        exp_adr = v.adr - WIN_BASE;
        @(negedge clk);
        cpu_adr = v.adr; cpu_rd = v.rd; cpu_wr = v.wr; cpu_dout = v.wdata;
        #1;
        chk({tag, " pause_first"}, 32'(cpu_pause), 32'(v.exp_hit));
        if (!v.exp_hit) begin
            saw = 1'b0;
            repeat (3) begin
                @(negedge clk);
                saw = saw | mem_req | cpu_pause;
            end
            chk({tag, " no_activity"}, 32'(saw), 32'(1'b0));
        end else begin
            @(negedge clk);
            chk({tag, " req"}, 32'(mem_req), 32'(1'b1));
            chk({tag, " adr"}, 32'(mem_adr), 32'(exp_adr));
            chk({tag, " we"},  32'(mem_we),  32'(v.wr));
            if (v.wr) chk({tag, " wdata"}, 32'(mem_wdata), 32'(v.wdata));
            stable = 1'b1;
            repeat (v.delay) begin
                @(negedge clk);
                if (!(mem_req && cpu_pause && mem_adr == exp_adr && mem_we == v.wr)) stable = 1'b0;
            end
            chk({tag, " held"}, 32'(stable), 32'(1'b1));
            mem_ack = 1'b1;
            if (mem_we) begin
                ext_mem[mem_adr[14:0]] = mem_wdata;
                mem_rdata = 8'($urandom);
            end else begin
                mem_rdata = ext_mem[mem_adr[14:0]];
            end
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = '0;
            #1;
            chk({tag, " pause_released"}, 32'(cpu_pause), 32'(1'b0));
            chk({tag, " req_dropped"},    32'(mem_req),   32'(1'b0));
        end
        chk({tag, " din"}, 32'(cpu_din), 32'(v.exp_din));
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_intreq(output int w);
        w = 0;
        while (!cpu_intreq && w < 6) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic count_high(output int h);
        h = 0;
        while (cpu_intreq && h < 3 * T) begin
            h++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w, h;
        reset_n = 1'b0; cpu_adr = 16'h1234; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_dout = '0;
        cpu_intack = 1'b0; vblank = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        for (int i = 0; i < 32768; i++) ext_mem[i] = '0;
        ext_mem[15'h1234] = 8'hA5;
        ext_mem[15'h7FFF] = 8'h5A;
        ext_mem[15'h0100] = 8'h61;
        ext_mem[15'h0101] = 8'h62;

        #12;
        chk("rst cpu_din",    32'(cpu_din),    32'(8'h00));
        chk("rst pause",      32'(cpu_pause),  32'(1'b0));
        chk("rst intreq",     32'(cpu_intreq), 32'(1'b0));
        chk("rst mem_req",    32'(mem_req),    32'(1'b0));
        chk("rst mem_we",     32'(mem_we),     32'(1'b0));
        chk("rst mem_adr",    32'(mem_adr),    32'(16'h0000));
        chk("rst mem_wdata",  32'(mem_wdata),  32'(8'h00));
        cpu_rd = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{16'h1234, 1'b1, 1'b0, 8'h00, 5, 1'b1, 8'hA5};
        vecs[1] = '{16'h0010, 1'b0, 1'b1, 8'h3C, 2, 1'b1, 8'hA5};
        vecs[2] = '{16'h8000, 1'b1, 1'b0, 8'h00, 0, 1'b0, 8'hA5};
        vecs[3] = '{16'h0010, 1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h3C};
        vecs[4] = '{16'h0020, 1'b1, 1'b1, 8'h77, 1, 1'b1, 8'h3C};
        vecs[5] = '{16'h0020, 1'b1, 1'b0, 8'h00, 3, 1'b1, 8'h77};
        vecs[6] = '{16'hFFFF, 1'b0, 1'b1, 8'h11, 0, 1'b0, 8'h77};
        vecs[7] = '{16'h7FFF, 1'b1, 1'b0, 8'h00, 1, 1'b1, 8'h5A};
        vecs[8] = '{16'h0000, 1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h00};
        for (int i = 0; i < 9; i++) access(vecs[i], $sformatf("vec%0d", i));

        // back-to-back reads with the strobe held and only the address changing
        @(negedge clk);
        cpu_adr = 16'h0100; cpu_rd = 1'b1;
        #1 chk("b2b pause", 32'(cpu_pause), 32'(1'b1));
        @(negedge clk);
        chk("b2b req1", 32'(mem_req), 32'(1'b1));
        mem_ack = 1'b1; mem_rdata = ext_mem[mem_adr[14:0]];
        @(negedge clk);
        mem_ack = 1'b0; cpu_adr = 16'h0101;
        #1;
        chk("b2b gap",  32'(mem_req), 32'(1'b0));
        chk("b2b din1", 32'(cpu_din), 32'(8'h61));
        for (int c = 0; c < 6 && !mem_req; c++) @(negedge clk);
        chk("b2b req2",  32'(mem_req), 32'(1'b1));
        chk("b2b adr2",  32'(mem_adr), 32'(16'h0101));
        mem_ack = 1'b1; mem_rdata = ext_mem[mem_adr[14:0]];
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("b2b din2",  32'(cpu_din),   32'(8'h62));
        chk("b2b pause", 32'(cpu_pause), 32'(1'b0));
        cpu_rd = 1'b0;
        @(negedge clk);

        // spurious ack while idle must not disturb anything
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        chk("spur din", 32'(cpu_din), 32'(8'h62));
        chk("spur req", 32'(mem_req), 32'(1'b0));
        access('{16'h1234, 1'b1, 1'b0, 8'h00, 1, 1'b1, 8'hA5}, "post_spur");

        // interrupt: latency, intack clear, timeout, edge coincident with intack
        @(negedge clk);
        vblank = 1'b1;
        wait_intreq(w);
        chk("irq set",     32'(cpu_intreq), 32'(1'b1));
        chk("irq latency", 32'(w <= 3),     32'(1'b1));
        cpu_intack = 1'b1;
        @(negedge clk);
        cpu_intack = 1'b0;
        #1 chk("irq ack clear", 32'(cpu_intreq), 32'(1'b0));
        vblank = 1'b0;
        repeat (4) @(negedge clk);
        vblank = 1'b1;
        wait_intreq(w);
        count_high(h);
        chk("irq timeout", 32'(h), 32'(T));
        vblank = 1'b0;
        repeat (4) @(negedge clk);
        vblank = 1'b1;
        wait_intreq(w);
        vblank = 1'b0;
        repeat (4) @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cpu_intack = 1'b1;
        @(negedge clk);
        cpu_intack = 1'b0;
        #1 chk("irq set_wins", 32'(cpu_intreq), 32'(1'b1));
        count_high(h);
        chk("irq reload", 32'(h), 32'(T));
        vblank = 1'b0;
        repeat (4) @(negedge clk);

        // asynchronous reset in the middle of a request
        vblank = 1'b1;
        wait_intreq(w);
        cpu_adr = 16'h0200; cpu_rd = 1'b1;
        @(negedge clk);
        chk("rstreq req", 32'(mem_req), 32'(1'b1));
        #2 reset_n = 1'b0;
        vblank = 1'b0;
        #1;
        chk("rstreq mem_req", 32'(mem_req),    32'(1'b0));
        chk("rstreq pause",   32'(cpu_pause),  32'(1'b0));
        chk("rstreq intreq",  32'(cpu_intreq), 32'(1'b0));
        @(negedge clk);
        reset_n = 1'b1; cpu_rd = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'hC3;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        chk("late ack din", 32'(cpu_din), 32'(8'h00));
        chk("late ack req", 32'(mem_req), 32'(1'b0));
        @(negedge clk);

        // randomized accesses against the window/shadow-memory model
        for (int i = 0; i < 32768; i++) begin
            ext_mem[i] = 8'($urandom);
            shadow[i]  = ext_mem[i];
        end
        cur_din = 8'h00;
        for (int i = 0; i < 120; i++) begin
            vec_t        v;
            int          k, sel;
            logic [15:0] off;
            k   = $urandom_range(0, 2);
            sel = $urandom_range(0, 9);
            if (sel < 6)      v.adr = WIN_BASE + 16'($urandom_range(0, 15));
            else if (sel < 8) v.adr = 16'($urandom_range(32'(WIN_BASE), 32'(WIN_TOP)));
            else              v.adr = 16'($urandom);
            v.rd      = (k != 1);
            v.wr      = (k != 0);
            v.wdata   = 8'($urandom);
            v.delay   = $urandom_range(0, 6);
            v.exp_hit = (v.adr >= WIN_BASE) && (v.adr <= WIN_TOP);
            off       = v.adr - WIN_BASE;
            if (v.exp_hit && v.wr)       shadow[off[14:0]] = v.wdata;
            else if (v.exp_hit && v.rd)  cur_din = shadow[off[14:0]];
            v.exp_din = cur_din;
            access(v, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
